button_debouncer: RTL and testbench

//   Conditions the raw asynchronous push-button input before it reaches the LED/colour control logic in top.

---
 rtl/button_pkg.sv | 18 +
 rtl/button_debouncer_sync_ff.sv | 25 ++
 rtl/button_debouncer.sv | 178 +++++++++++++++++
 tb/tb_button_debouncer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and helpers for the push-button conditioning logic
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Width able to hold the larger of the two cycle targets without wrapping.
    function automatic int cnt_width(int a, int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_debouncer_sync_ff.sv
// rtl/button_debouncer_sync_ff.sv - multi-flop synchroniser for asynchronous inputs
// Reset drives every stage to RESET_VAL so the synchronised value is benign while held in reset.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronised, debounced push button with press/release/long-press strobes
// All outputs are registered; every decision is taken from the synchronised sample only.
module button_debouncer
    import button_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 64,
    parameter bit BUTTON_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic button_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse,
    output logic long_held
);

    localparam int             CW        = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
    localparam bit             DEB_ONE   = (DEBOUNCE_CYCLES == 1);
    localparam bit             LONG_EN   = (LONG_PRESS_CYCLES > 0);
    localparam logic [CW-1:0]  CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0]  DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  HOLD_MAX  = LONG_EN ? CW'(LONG_PRESS_CYCLES) : '0;
    localparam logic [CW-1:0]  LONG_LAST = LONG_EN ? CW'(LONG_PRESS_CYCLES - 1) : '0;

    logic          w_btn_raw;
    logic          w_sync_q;

    btn_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_hold_cnt;
    logic          r_level;
    logic          r_press_pulse;
    logic          r_release_pulse;
    logic          r_long_pulse;
    logic          r_long_held;

    btn_state_t    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] w_hold_nxt;
    logic          w_accept_press;
    logic          w_accept_release;
    logic          w_hold_step;
    logic          w_long_fire;

    // Inversion happens ahead of the chain so reset value 0 always means "not pressed".
    assign w_btn_raw = button_in ^ BUTTON_ACTIVE_LOW;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_btn_raw),
        .o_q   (w_sync_q)
    );

    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_accept_press   = 1'b0;
        w_accept_release = 1'b0;
        w_hold_step      = 1'b0;
        case (r_state)
            RELEASED: begin
                if (w_sync_q) begin
                    if (DEB_ONE) begin
                        w_accept_press = 1'b1;
                    end else begin
                        w_state_nxt = PRESS_WAIT;
                        w_cnt_nxt   = CW'(1);
                    end
                end
            end
            PRESS_WAIT: begin
                if (!w_sync_q) begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_accept_press = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            PRESSED: begin
                if (w_sync_q) begin
                    w_hold_step = 1'b1;
                end else if (DEB_ONE) begin
                    w_accept_release = 1'b1;
                end else begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                // A sample back at 1 counts as held time, so only the low samples freeze hold_cnt.
                if (w_sync_q) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                    w_hold_step = 1'b1;
                end else if (r_cnt == DEB_LAST) begin
                    w_accept_release = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = RELEASED;
                w_cnt_nxt   = '0;
            end
        endcase
        if (w_accept_press) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
        end
        if (w_accept_release) begin
            w_state_nxt = RELEASED;
            w_cnt_nxt   = '0;
        end
    end

    always_comb begin
        w_hold_nxt  = r_hold_cnt;
        w_long_fire = 1'b0;
        if (w_accept_press) begin
            w_hold_nxt = '0;
        end else if (w_hold_step && LONG_EN) begin
            if (r_hold_cnt != HOLD_MAX) begin
                w_hold_nxt = r_hold_cnt + CW'(1);
            end
            w_long_fire = (r_hold_cnt == LONG_LAST) && !r_long_held;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= RELEASED;
            r_cnt           <= '0;
            r_hold_cnt      <= '0;
            r_level         <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
            r_long_held     <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_hold_cnt      <= w_hold_nxt;
            r_press_pulse   <= w_accept_press;
            r_release_pulse <= w_accept_release;
            r_long_pulse    <= w_long_fire;
            if (w_accept_press) begin
                r_level <= 1'b1;
            end else if (w_accept_release) begin
                r_level <= 1'b0;
            end
            if (w_accept_release) begin
                r_long_held <= 1'b0;
            end else if (w_long_fire) begin
                r_long_held <= 1'b1;
            end
        end
    end

    assign button_level     = r_level;
    assign press_pulse      = r_press_pulse;
    assign release_pulse    = r_release_pulse;
    assign long_press_pulse = r_long_pulse;
    assign long_held        = r_long_held;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed-vector bench for button_debouncer
module tb_button_debouncer;

    localparam int I_LEVEL = 4;
    localparam int I_PRESS = 3;
    localparam int I_REL   = 2;
    localparam int I_LONG  = 1;
    localparam int I_HELD  = 0;

    typedef struct packed {
        logic       b;
        logic [4:0] exp;
    } vec_t;

    logic clk;
    logic reset;
    logic button_in;
    logic button_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press_pulse;
    logic long_held;
    logic [4:0] outs;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    button_debouncer #(
        .SYNC_STAGES       (2),
        .DEBOUNCE_CYCLES   (4),
        .LONG_PRESS_CYCLES (20),
        .BUTTON_ACTIVE_LOW (1'b0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .button_in        (button_in),
        .button_level     (button_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse),
        .long_held        (long_held)
    );

    assign outs = {button_level, press_pulse, release_pulse, long_press_pulse, long_held};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic b);
        button_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic b, input int n, input logic [4:0] e);
        vec_t v;
        v.b   = b;
        v.exp = e;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic add_bounce_release();
        add(1'b0, 1, 5'b10000);
        add(1'b1, 1, 5'b10000);
        add(1'b0, 1, 5'b10000);
        add(1'b1, 1, 5'b10000);
        add(1'b0, 5, 5'b10000);
        add(1'b0, 1, 5'b00100);
        add(1'b0, 5, 5'b00000);
    endtask

    task automatic wait_evt(input int sel, input logic b, input int max, output int idx);
        idx = -1;
        for (int k = 1; k <= max; k++) begin
            step(b);
            if (outs[sel] === 1'b1) begin
                idx = k;
                break;
            end
        end
    endtask

    initial begin
        int idx;
        int long_at;
        int n_long;
        int n_rel;
        int n_press;
        logic held_ok;
        logic level_ok;

        reset     = 1'b0;
        button_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {27'd0, outs}, 32'd0);
        button_in = 1'b0;
        reset     = 1'b1;

        // 1-clk spike, then a bounced press/hold/bounced release, twice
        add(1'b1, 1, 5'b00000);
        add(1'b0, 29, 5'b00000);
        add(1'b1, 5, 5'b00000);
        add(1'b1, 1, 5'b11000);
        add(1'b1, 4, 5'b10000);
        add_bounce_release();
        add(1'b1, 1, 5'b00000);
        add(1'b0, 1, 5'b00000);
        add(1'b1, 1, 5'b00000);
        add(1'b0, 1, 5'b00000);
        add(1'b1, 5, 5'b00000);
        add(1'b1, 1, 5'b11000);
        add(1'b1, 3, 5'b10000);
        add_bounce_release();

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].b);
            chk($sformatf("vec[%0d]", i), {27'd0, outs}, {27'd0, vecs[i].exp});
        end

        // long press: 40 clks of hold
        wait_evt(I_PRESS, 1'b1, 20, idx);
        chk("t4_press_latency", idx, 6);
        long_at = -1;
        n_long  = 0;
        held_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1);
            if (long_press_pulse) begin
                n_long++;
                if (long_at < 0) long_at = i;
            end
            if (i >= 20 && long_held !== 1'b1) held_ok = 1'b0;
        end
        chk("t4_long_latency", long_at, 20);
        chk("t4_long_once", n_long, 1);
        chk("t4_long_held", {31'd0, held_ok}, 32'd1);
        wait_evt(I_REL, 1'b0, 20, idx);
        chk("t4_release_latency", idx, 6);
        chk("t4_held_cleared", {31'd0, long_held}, 32'd0);

        // release glitch during hold freezes the long-press count
        wait_evt(I_PRESS, 1'b1, 20, idx);
        chk("t5_press_latency", idx, 6);
        long_at  = -1;
        n_rel    = 0;
        n_press  = 0;
        level_ok = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step((i == 16 || i == 17) ? 1'b0 : 1'b1);
            if (long_press_pulse && long_at < 0) long_at = i;
            if (release_pulse) n_rel++;
            if (press_pulse) n_press++;
            if (button_level !== 1'b1) level_ok = 1'b0;
        end
        chk("t5_long_latency", long_at, 22);
        chk("t5_no_release", n_rel, 0);
        chk("t5_no_repress", n_press, 0);
        chk("t5_level_held", {31'd0, level_ok}, 32'd1);
        wait_evt(I_REL, 1'b0, 20, idx);
        chk("t5_release_latency", idx, 6);

        // reset while pressed and held
        wait_evt(I_PRESS, 1'b1, 20, idx);
        chk("t6_press_latency", idx, 6);
        repeat (3) step(1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_async_clear", {27'd0, outs}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            chk($sformatf("t6_in_reset[%0d]", i), {27'd0, outs}, 32'd0);
        end
        reset = 1'b1;
        wait_evt(I_PRESS, 1'b1, 20, idx);
        chk("t6_repress_latency", idx, 6);
        chk("t6_level_after", {31'd0, button_level}, 32'd1);
        wait_evt(I_REL, 1'b0, 20, idx);
        chk("t6_release_latency", idx, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
